// File: rtl/p12_cfg_loader.sv
// Configuration loader for the 8x8 rotating-tile grid: buffers a byte stream into
// scan frames, shifts each into the grid chain and strobes the matching latch plane.
module p12_cfg_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CFG_PULSE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       lb_en,
    input  logic [1:0] lbc_sel,
    output logic       se,
    output logic       sc,
    output logic [1:0] cfg,
    output logic       lb,
    output logic [1:0] lbc,
    output logic       busy,
    output logic [1:0] frame,
    output logic       done
);

    localparam int BYTES = CHAIN_LEN / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SCW   = $clog2(CHAIN_LEN + 1);
    localparam int PCW   = (CFG_PULSE > 1) ? $clog2(CFG_PULSE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        STROBE,
        FINISH
    } state_t;

    state_t               state;
    logic [CHAIN_LEN-1:0] frame_buf;
    logic [CHAIN_LEN-1:0] fill_buf;
    logic [BCW-1:0]       byte_cnt;
    logic [SCW-1:0]       shift_cnt;
    logic [PCW-1:0]       pulse_cnt;
    logic                 loaded;
    logic                 start_go;
    logic                 finish_go;
    logic                 busy_nxt;
    logic                 loaded_nxt;

    // Next-cycle busy/loaded let the registered loop-breaker outputs switch in
    // the same cycle as busy itself, so lb is never released while busy=1.
    always_comb begin
        fill_buf = frame_buf;
        fill_buf[{byte_cnt, 3'b000} +: 8] = din;
        start_go   = (state == IDLE) && start;
        finish_go  = (state == SHIFT) && (shift_cnt == '0) && (frame == 2'd3);
        busy_nxt   = (busy || start_go) && !finish_go;
        loaded_nxt = loaded || finish_go;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            se        <= 1'b0;
            sc        <= 1'b0;
            cfg       <= 2'd0;
            lb        <= 1'b1;
            lbc       <= 2'd0;
            din_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame     <= 2'd0;
            loaded    <= 1'b0;
            byte_cnt  <= '0;
            shift_cnt <= '0;
            pulse_cnt <= '0;
        end else begin
            busy   <= busy_nxt;
            loaded <= loaded_nxt;
            done   <= finish_go;
            if (busy_nxt || !loaded_nxt) begin
                lb  <= 1'b1;
                lbc <= 2'd0;
            end else begin
                lb  <= lb_en;
                lbc <= lbc_sel;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        frame     <= 2'd0;
                        byte_cnt  <= '0;
                        din_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (din_valid && din_ready) begin
                        if (byte_cnt == BCW'(BYTES - 1)) begin
                            // Bit 0 goes straight to sc; the buffer keeps the rest.
                            frame_buf <= fill_buf >> 1;
                            sc        <= fill_buf[0];
                            se        <= 1'b1;
                            din_ready <= 1'b0;
                            shift_cnt <= SCW'(CHAIN_LEN - 1);
                            state     <= SHIFT;
                        end else begin
                            frame_buf <= fill_buf;
                            byte_cnt  <= byte_cnt + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_cnt != '0) begin
                        sc        <= frame_buf[0];
                        frame_buf <= frame_buf >> 1;
                        shift_cnt <= shift_cnt - 1'b1;
                    end else begin
                        se <= 1'b0;
                        sc <= 1'b0;
                        if (frame == 2'd3) begin
                            state <= FINISH;
                        end else begin
                            state     <= STROBE;
                            cfg       <= frame + 2'd1;
                            pulse_cnt <= PCW'(CFG_PULSE - 1);
                        end
                    end
                end
                STROBE: begin
                    if (pulse_cnt != '0) begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end else begin
                        cfg       <= 2'd0;
                        frame     <= frame + 2'd1;
                        byte_cnt  <= '0;
                        din_ready <= 1'b1;
                        state     <= FILL;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p12_cfg_loader.sv
// Directed bench for p12_cfg_loader: vector tables for idle/loop-breaker behaviour
// plus cycle-exact sequences for full loads, gaps, bit order, ignored inputs and reset.
module tb_p12_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       lb_en;
    logic [1:0] lbc_sel;
    logic       se;
    logic       sc;
    logic [1:0] cfg;
    logic       lb;
    logic [1:0] lbc;
    logic       busy;
    logic [1:0] frame;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frm [0:3][0:7];
    logic [63:0] chain;
    logic [63:0] ref_stream [0:3];

    typedef struct {
        logic       lb_en;
        logic [1:0] lbc_sel;
        logic       dv;
        logic       exp_lb;
        logic [1:0] exp_lbc;
    } vec_t;

    vec_t pre_vecs  [0:2];
    vec_t post_vecs [0:3];

    p12_cfg_loader #(.CHAIN_LEN(64), .CFG_PULSE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .lb_en     (lb_en),
        .lbc_sel   (lbc_sel),
        .se        (se),
        .sc        (sc),
        .cfg       (cfg),
        .lb        (lb),
        .lbc       (lbc),
        .busy      (busy),
        .frame     (frame),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_frames_seq;
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 8; k++)
                frm[f][k] = 8'(f * 8 + k + 1);
    endtask

    task automatic apply_vecs(input vec_t v, input string tag);
        lb_en     = v.lb_en;
        lbc_sel   = v.lbc_sel;
        din_valid = v.dv;
        tick;
        chk({tag, "_lb"}, lb, v.exp_lb);
        chk({tag, "_lbc"}, lbc, v.exp_lbc);
        chk({tag, "_idle"}, {se, cfg, din_ready, busy}, 5'b0);
    endtask

    // One 4-frame load from frm[][]. gap: idle cycles before each byte.
    // poke: start/din_valid pulse mid-SHIFT of frame 1. abort: reset in STROBE of frame 2.
    task automatic do_load(input int gap, input bit poke, input bit abort, input bit tail_chk,
                           input bit save_ref);
        logic [63:0] cap;
        logic [63:0] expv;
        int          se_cnt;
        chain = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_busy_ready", {busy, din_ready}, 2'b11);
        chk("start_lb_forced", {lb, lbc}, 3'b100);
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin
                for (int g = 0; g < gap; g++) begin
                    din_valid = 1'b0;
                    tick;
                    chk("gap_no_se", {se, din_ready}, 2'b01);
                end
                din       = frm[f][k];
                din_valid = 1'b1;
                chk("fill_ready", {se, din_ready}, 2'b01);
                tick;
            end
            din_valid = 1'b0;
            chk("shift_frame_idx", frame, 64'(f));
            chk("shift_lb_forced", {lb, lbc}, 3'b100);
            se_cnt = 0;
            for (int i = 0; i < 64; i++) begin
                cap[i] = sc;
                if (se) begin
                    se_cnt++;
                    chain = {chain[62:0], sc};
                end
                if (poke && f == 1 && i == 10) begin
                    start     = 1'b1;
                    din       = 8'hFF;
                    din_valid = 1'b1;
                    chk("shift_not_ready", din_ready, 1'b0);
                end
                tick;
                start     = 1'b0;
                din_valid = 1'b0;
            end
            for (int k = 0; k < 8; k++) expv[8*k +: 8] = frm[f][k];
            chk("se_cycles", 64'(se_cnt), 64);
            chk("stream", cap, expv);
            if (save_ref) ref_stream[f] = cap;
            else chk("stream_vs_ref", cap, ref_stream[f]);
            if (f == 0 && !tail_chk) chk("first_sc_bit", cap[0], 1'b1);
            if (f == 0 && tail_chk) chk("chain_tail_a5", chain[63:56], 8'hA5);
            chk("se_sc_off", {se, sc}, 2'b00);
            if (f < 3) begin
                chk("cfg_pulse1", cfg, 64'(f + 1));
                if (abort && f == 2) begin
                    rst = 1'b1;
                    tick;
                    rst = 1'b0;
                    chk("abort_cfg", cfg, 2'd0);
                    chk("abort_busy_lb", {busy, lb, lbc}, 4'b0100);
                    chk("abort_misc", {se, sc, din_ready, done, frame}, 6'b0);
                    return;
                end
                tick;
                chk("cfg_pulse2", cfg, 64'(f + 1));
                tick;
                chk("cfg_cleared", cfg, 2'd0);
                chk("next_fill", {din_ready, frame}, {1'b1, 2'(f + 1)});
            end else begin
                chk("done_pulse", {done, busy, cfg}, 4'b1000);
                tick;
                chk("done_clear", {done, busy, din_ready}, 3'b000);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        lb_en     = 1'b0;
        lbc_sel   = 2'd2;

        pre_vecs[0]  = '{lb_en: 1'b0, lbc_sel: 2'd2, dv: 1'b0, exp_lb: 1'b1, exp_lbc: 2'd0};
        pre_vecs[1]  = '{lb_en: 1'b1, lbc_sel: 2'd3, dv: 1'b1, exp_lb: 1'b1, exp_lbc: 2'd0};
        pre_vecs[2]  = '{lb_en: 1'b0, lbc_sel: 2'd1, dv: 1'b0, exp_lb: 1'b1, exp_lbc: 2'd0};
        post_vecs[0] = '{lb_en: 1'b1, lbc_sel: 2'd3, dv: 1'b0, exp_lb: 1'b1, exp_lbc: 2'd3};
        post_vecs[1] = '{lb_en: 1'b0, lbc_sel: 2'd1, dv: 1'b1, exp_lb: 1'b0, exp_lbc: 2'd1};
        post_vecs[2] = '{lb_en: 1'b1, lbc_sel: 2'd2, dv: 1'b0, exp_lb: 1'b1, exp_lbc: 2'd2};
        post_vecs[3] = '{lb_en: 1'b0, lbc_sel: 2'd0, dv: 1'b0, exp_lb: 1'b0, exp_lbc: 2'd0};

        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("reset_outputs", {se, sc, cfg, lb, lbc}, 7'b0000100);
        chk("reset_status", {din_ready, busy, done, frame}, 5'b0);

        for (int i = 0; i < 3; i++) apply_vecs(pre_vecs[i], "pre_load");

        // Back-to-back bytes 0x01..0x20
        set_frames_seq();
        lb_en   = 1'b0;
        lbc_sel = 2'd2;
        do_load(0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply_vecs(post_vecs[i], "post_load");

        // Same data with 3-cycle gaps between bytes
        lb_en   = 1'b0;
        lbc_sel = 2'd2;
        do_load(3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bit order plus ignored start/din_valid during frame 1 SHIFT
        set_frames_seq();
        for (int k = 0; k < 8; k++) frm[0][k] = 8'h00;
        frm[0][0] = 8'hA5;
        do_load(0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset in STROBE of frame 2, then a fresh load from frame 0
        set_frames_seq();
        lb_en   = 1'b0;
        lbc_sel = 2'd2;
        do_load(0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        chk("after_abort_lb_forced", {lb, lbc, busy}, 4'b1000);
        do_load(1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_vecs(post_vecs[1], "reload");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
